// File: rtl/mio_bus_responder.sv
// MIO bus responder: services CPU word reads/writes from an internal RAM or a
// small peripheral register file (LED, CYCLE, SW, STATUS), with programmable wait states.
module mio_bus_responder #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2,
  parameter int IO_LAT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr_bus,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        bus_err
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {RG_RAM = 2'd0, RG_IO = 2'd1, RG_UNM = 2'd2} region_t;

  state_t              state_r, state_s;
  region_t             region_r, region_s;
  logic [3:0]          cnt_r, cnt_s, lat_s;
  logic                latch_s, req_s, done_s;
  logic [RAM_AW-1:0]   idx_r;
  logic [1:0]          io_sel_r;
  logic [31:0]         wdata_r, rdata_s, cycle_r, data_in_r;
  logic                wr_r, both_r, ready_r, err_r, ram_we_s;
  logic [15:0]         led_r;
  logic [31:0]         mem_r [0:(2**RAM_AW)-1];
  logic                unused_s;

  assign unused_s = ^Addr_bus[1:0];
  assign req_s    = CPU_MIO & (MemRead | MemWrite);
  assign done_s   = (state_r == ST_DONE);
  assign ram_we_s = done_s & wr_r & (region_r == RG_RAM);

  // Region decode of the live address and the wait-state count it implies
  always_comb begin
    region_s = RG_UNM;
    if (Addr_bus[31:28] == 4'hF) begin
      region_s = RG_IO;
    end else if ((Addr_bus >> (RAM_AW + 2)) == 32'd0) begin
      region_s = RG_RAM;
    end else begin
      region_s = RG_UNM;
    end
    case (region_s)
      RG_RAM:  lat_s = 4'(RAM_LAT);
      RG_IO:   lat_s = 4'(IO_LAT);
      default: lat_s = 4'd0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= (state_s == ST_DONE);
    end
  end

  // FSM next-state logic; requests are only accepted in IDLE
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    latch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          latch_s = 1'b1;
          cnt_s   = lat_s;
          state_s = (lat_s != 4'd0) ? ST_WAIT : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Read data mux, evaluated in DONE from the latched access
  always_comb begin
    rdata_s = 32'd0;
    case (region_r)
      RG_RAM: rdata_s = mem_r[idx_r];
      RG_IO: begin
        case (io_sel_r)
          2'd0:    rdata_s = {16'd0, led_r};
          2'd1:    rdata_s = cycle_r;
          2'd2:    rdata_s = {16'd0, sw_in};
          default: rdata_s = {31'd0, err_r};
        endcase
      end
      default: rdata_s = 32'd0;
    endcase
  end

  // Request latches, peripheral registers and read-data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      region_r  <= RG_UNM;
      idx_r     <= '0;
      io_sel_r  <= 2'd0;
      wdata_r   <= 32'd0;
      wr_r      <= 1'b0;
      both_r    <= 1'b0;
      cycle_r   <= 32'd0;
      led_r     <= 16'd0;
      err_r     <= 1'b0;
      data_in_r <= 32'd0;
    end else begin
      if (latch_s) begin
        region_r <= region_s;
        idx_r    <= Addr_bus[RAM_AW+1:2];
        io_sel_r <= Addr_bus[3:2];
        wdata_r  <= Data_out;
        wr_r     <= MemWrite;
        both_r   <= MemRead & MemWrite;
      end
      // A CYCLE write in DONE wins over the free-running increment
      if (done_s && wr_r && region_r == RG_IO && io_sel_r == 2'd1) begin
        cycle_r <= 32'd0;
      end else begin
        cycle_r <= cycle_r + 32'd1;
      end
      if (done_s && wr_r && region_r == RG_IO && io_sel_r == 2'd0) begin
        led_r <= wdata_r[15:0];
      end
      if (done_s && (both_r || region_r == RG_UNM)) begin
        err_r <= 1'b1;
      end else if (done_s && wr_r && region_r == RG_IO && io_sel_r == 2'd3) begin
        err_r <= 1'b0;
      end
      if (done_s && !wr_r) begin
        data_in_r <= rdata_s;
      end
    end
  end

  // Word RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign Data_in   = data_in_r;
  assign MIO_ready = ready_r;
  assign led_out   = led_r;
  assign bus_err   = err_r;

endmodule
